// File: rtl/noc_pkg.sv
// Purpose: shared types and constants for the NoC output-port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 16;
    localparam int IDX_W     = 3;
    localparam int IDLE_W    = 8;

    // Input port index order as seen by every output arbiter.
    typedef enum logic [IDX_W-1:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_W = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Fold a sum of two port indices (each 0..4) back into 0..4.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [3:0] v);
        logic [3:0] folded;
        folded = (v >= 4'd5) ? (v - 4'd5) : v;
        return folded[IDX_W-1:0];
    endfunction

    // One-hot decode of a port index.
    function automatic logic [NUM_PORTS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == IDX_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_pick5.sv
// Purpose: combinational 5-way round-robin search starting at ptr, wrapping modulo 5.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req - request vector; ptr - first index to consider;
//        gnt_idx - winning index (0 when nothing requests); any - at least one request.
module rr_pick5
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 any
);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;

    // An out-of-range pointer can never be produced by the arbiter, but
    // clamping keeps the index math inside the vector regardless.
    assign base = (ptr > 3'd4) ? 3'd0 : ptr;

    // Walk the offsets from farthest to nearest so the nearest requester
    // (the one closest to ptr going upward) is the last, and winning, write.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = wrap_idx({1'b0, base} + 4'(i));
            if (req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Purpose: wormhole output-port arbiter; locks one input from head to tail flit, round-robin between packets.
// Latency: grant one cycle after a request in IDLE; release edge follows the tail transfer (or idle timeout).
// Backpressure: out_ready_i=0 stalls transfers but the lock is held; other requesters wait until release.
// Ports: clk_i/rst_ni - clock and synchronous active-low reset; req_i/tail_i - per-input flit present / tail;
//        out_ready_i - downstream accept; grant_o/sel_o/en_o - registered owner (one-hot, index, enable);
//        valid_o - owner has a flit this cycle; timeout_o - one-cycle pulse after a forced release.
module noc_output_arbiter
    import noc_pkg::*;
#(
    parameter int TIMEOUT = 0
)
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0] tail_i,
    input  logic                 out_ready_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]     sel_o,
    output logic                 en_o,
    output logic                 valid_o,
    output logic                 timeout_o
);

    // The idle counter is 8 bits wide, so the usable limit is 0..255.
    localparam int              TIMEOUT_CLAMP = (TIMEOUT < 0)   ? 0   :
                                                (TIMEOUT > 255) ? 255 : TIMEOUT;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT  = IDLE_W'(TIMEOUT_CLAMP);
    localparam bit              TIMEOUT_EN    = (TIMEOUT_CLAMP != 0);

    arb_state_e             state_q;
    logic [IDX_W-1:0]       owner_q;
    logic [NUM_PORTS-1:0]   grant_q;
    logic                   en_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDLE_W-1:0]      idle_cnt_q;
    logic                   timeout_q;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   owner_req;
    logic                   xfer;
    logic                   tail_done;
    logic                   expired;
    logic [IDX_W-1:0]       next_ptr;

    rr_pick5 u_pick (
        .req     (req_i),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign owner_req = req_i[owner_q];
    // en_q is low in IDLE, which also forces valid_o low there.
    assign valid_o   = en_q & owner_req;
    assign xfer      = valid_o & out_ready_i;
    assign tail_done = xfer & tail_i[owner_q];
    // The limit is compared against the registered count, so a tail that
    // lands on the cycle the count sits at the limit takes priority below.
    assign expired   = TIMEOUT_EN && (idle_cnt_q >= IDLE_LIMIT);
    assign next_ptr  = wrap_idx({1'b0, owner_q} + 4'd1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ARB_IDLE;
            owner_q    <= '0;
            grant_q    <= '0;
            en_q       <= 1'b0;
            ptr_q      <= '0;
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    idle_cnt_q <= '0;
                    if (pick_any) begin
                        state_q <= ARB_LOCKED;
                        owner_q <= pick_idx;
                        grant_q <= idx_onehot(pick_idx);
                        en_q    <= 1'b1;
                    end
                end
                ARB_LOCKED: begin
                    if (tail_done || expired) begin
                        state_q    <= ARB_IDLE;
                        owner_q    <= '0;
                        grant_q    <= '0;
                        en_q       <= 1'b0;
                        ptr_q      <= next_ptr;
                        idle_cnt_q <= '0;
                        // Only a release the tail did not cause is reported.
                        timeout_q  <= ~tail_done;
                    end else if (owner_req) begin
                        idle_cnt_q <= '0;
                    end else if (TIMEOUT_EN && (idle_cnt_q != {IDLE_W{1'b1}})) begin
                        idle_cnt_q <= idle_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign sel_o     = owner_q;
    assign en_o      = en_q;
    assign timeout_o = timeout_q;

endmodule
